// File: rtl/complex_mult_pkg.sv
// Shared constants for the complex multiplier at its default operand width.
package complex_mult_pkg;
  localparam int W       = 8;
  localparam int PROD_W  = 2 * W;
  localparam int SUM_W   = 2 * W + 1;
  localparam int SAT_MAX = (2 ** (W - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W - 1));
endpackage

// File: rtl/cmult_sat.sv
// Signed saturation from a wide sum down to the result width.
module cmult_sat #(
  parameter int IN_W  = complex_mult_pkg::SUM_W,
  parameter int OUT_W = complex_mult_pkg::W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  // Largest and smallest OUT_W values, sign-extended to IN_W bits.
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp out-of-range values, pass in-range values through unchanged.
  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/complex_mult.sv
// Three-stage pipelined signed complex multiplier with saturated outputs.
module complex_mult #(
  parameter int W = complex_mult_pkg::W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] a2,
  input  logic signed [W-1:0] b2,
  output logic signed [W-1:0] res_re,
  output logic signed [W-1:0] res_im
);
  localparam int PROD_W = 2 * W;
  localparam int SUM_W  = 2 * W + 1;

  logic signed [W-1:0]      a1_q, b1_q, a2_q, b2_q;
  logic signed [W-1:0]      a1_d, b1_d, a2_d, b2_d;
  logic signed [PROD_W-1:0] p_aa_q, p_bb_q, p_ab_q, p_ba_q;
  logic signed [PROD_W-1:0] p_aa_d, p_bb_d, p_ab_d, p_ba_d;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [W-1:0]      sat_re, sat_im;
  logic signed [W-1:0]      res_re_q, res_im_q;
  logic signed [W-1:0]      res_re_d, res_im_d;

  // Stage 1 next-state: capture operands as presented.
  always_comb begin
    a1_d = a1;
    b1_d = b1;
    a2_d = a2;
    b2_d = b2;
  end

  // Stage 2 next-state: four full-precision signed products.
  always_comb begin
    p_aa_d = a1_q * a2_q;
    p_bb_d = b1_q * b2_q;
    p_ab_d = a1_q * b2_q;
    p_ba_d = b1_q * a2_q;
  end

  // Sign-extend products before combining so the sum cannot overflow.
  always_comb begin
    sum_re = SUM_W'(p_aa_q) - SUM_W'(p_bb_q);
    sum_im = SUM_W'(p_ab_q) + SUM_W'(p_ba_q);
  end

  cmult_sat #(.IN_W(SUM_W), .OUT_W(W)) u_sat_re (.din(sum_re), .dout(sat_re));
  cmult_sat #(.IN_W(SUM_W), .OUT_W(W)) u_sat_im (.din(sum_im), .dout(sat_im));

  // Stage 3 next-state: saturated results.
  always_comb begin
    res_re_d = sat_re;
    res_im_d = sat_im;
  end

  // All pipeline registers; reset clears every stage so nothing in flight survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q     <= '0;
      b1_q     <= '0;
      a2_q     <= '0;
      b2_q     <= '0;
      p_aa_q   <= '0;
      p_bb_q   <= '0;
      p_ab_q   <= '0;
      p_ba_q   <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
    end else begin
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      a2_q     <= a2_d;
      b2_q     <= b2_d;
      p_aa_q   <= p_aa_d;
      p_bb_q   <= p_bb_d;
      p_ab_q   <= p_ab_d;
      p_ba_q   <= p_ba_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
    end
  end

  assign res_re = res_re_q;
  assign res_im = res_im_q;
endmodule

// File: tb/tb_complex_mult.sv
// Directed bench for complex_mult with a latency-aligned expectation queue.
module tb_complex_mult;
  localparam int W = 8;

  typedef struct {
    int re;
    int im;
  } exp_t;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] a1, b1, a2, b2;
  logic signed [W-1:0] res_re, res_im;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  complex_mult #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a1     (a1),
    .b1     (b1),
    .a2     (a2),
    .b2     (b2),
    .res_re (res_re),
    .res_im (res_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // Called at a falling edge; drives one operand set, advances one cycle and
  // compares the output against the result due at this point.
  task automatic step(input int x1, input int y1, input int x2, input int y2,
                      input bit glitch);
    exp_t e;
    exp_t o;
    if (glitch) begin
      a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
      #1;
    end
    a1 = W'(x1); b1 = W'(y1); a2 = W'(x2); b2 = W'(y2);
    e.re = sat(x1 * x2 - y1 * y2);
    e.im = sat(x1 * y2 + y1 * x2);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = exp_q.pop_front();
    check("res_re", int'(res_re), o.re);
    check("res_im", int'(res_im), o.im);
  endtask

  // Pipeline is empty after reset: the first two outputs are zero.
  task automatic flush_model();
    exp_t z;
    z.re = 0;
    z.im = 0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;

    #2;
    check("reset_re_async", int'(res_re), 0);
    check("reset_im_async", int'(res_im), 0);
    @(negedge clk);
    a1 = 8'sd55; b1 = -8'sd9; a2 = 8'sd17; b2 = 8'sd3;
    @(negedge clk);
    check("reset_re_held", int'(res_re), 0);
    check("reset_im_held", int'(res_im), 0);
    rst = 1'b0;
    flush_model();

    // Single pulse then zeros.
    step(-2, 4, 3, -7, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);

    // Pulse every third cycle.
    for (int i = 0; i < 3; i++) begin
      step(-2, 4, 3, -7, 1'b0);
      step(0, 0, 0, 0, 1'b0);
      step(0, 0, 0, 0, 1'b0);
    end

    // Saturation boundaries.
    step(127, 127, 127, 127, 1'b0);
    step(-128, 0, -128, 0, 1'b0);
    step(0, 127, 0, 127, 1'b0);
    step(-128, -128, -128, -128, 1'b0);
    step(-128, -128, 127, 0, 1'b0);
    step(-3, 5, 7, 2, 1'b0);
    step(127, -128, 127, 127, 1'b0);

    // Inputs wiggle between edges; only the settled value counts.
    step(10, -20, 4, 5, 1'b1);
    step(-7, 3, -6, -2, 1'b1);

    // Back-to-back random operands.
    for (int i = 0; i < 20; i++) begin
      step(int'($signed(8'($urandom))), int'($signed(8'($urandom))),
           int'($signed(8'($urandom))), int'($signed(8'($urandom))), 1'b0);
    end

    // Load nonzero work into the pipeline, then reset mid-cycle.
    step(-2, 4, 3, -7, 1'b0);
    step(127, 127, 127, 127, 1'b0);
    a1 = 8'sd9; b1 = 8'sd9; a2 = 8'sd9; b2 = -8'sd9;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_re_async", int'(res_re), 0);
    check("midrst_im_async", int'(res_im), 0);
    @(posedge clk);
    #1;
    check("midrst_re_held", int'(res_re), 0);
    check("midrst_im_held", int'(res_im), 0);
    @(negedge clk);
    rst = 1'b0;
    flush_model();

    step(5, 6, 7, 8, 1'b0);
    step(-2, 4, 3, -7, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout after %0d tests", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
